// File: rtl/pipe_ctrl_pkg.sv
// Shared defines for the pipeline controller: source indices, default depths,
// stall-bus width and the redirect payload.
package pipe_ctrl_pkg;

    localparam int unsigned NREQ_DEF    = 5;
    localparam int unsigned DEPTH_W_DEF = 3;
    localparam int unsigned STALL_BUS_W = 6;
    localparam int unsigned PC_W        = 32;
    localparam int unsigned HOLD_W      = 4;

    // Stall-request source indices
    localparam int unsigned EX   = 0;
    localparam int unsigned BRU  = 1;
    localparam int unsigned CP0  = 2;
    localparam int unsigned LOAD = 3;
    localparam int unsigned FIFO = 4;

    // Fields 4..0: fifo, load, cp0, bru, ex
    localparam logic [NREQ_DEF*DEPTH_W_DEF-1:0] REQ_DEPTH_DEF =
        {3'd1, 3'd2, 3'd3, 3'd3, 3'd4};

    typedef enum logic {
        FL_IDLE = 1'b0,
        FL_HOLD = 1'b1
    } flush_state_e;

    typedef struct packed {
        logic            flush;
        logic [PC_W-1:0] pc;
    } redirect_t;

endpackage

// File: rtl/pipe_ctrl_depth.sv
// stall_depth_max: combinational max over the depth fields of all asserted
// stall requests, each field clamped to the number of stages.
module stall_depth_max
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NREQ    = NREQ_DEF,
    parameter int unsigned DEPTH_W = DEPTH_W_DEF,
    parameter int unsigned STAGES  = STALL_BUS_W,
    parameter logic [NREQ*DEPTH_W-1:0] REQ_DEPTH = REQ_DEPTH_DEF,
    parameter int unsigned DEP_W   = $clog2(STAGES + 1)
) (
    input  logic [NREQ-1:0]  req_i,
    output logic [DEP_W-1:0] depth_o
);

    function automatic logic [DEP_W-1:0] clamp_f(input logic [DEPTH_W-1:0] f);
        if (32'(f) > STAGES) begin
            return DEP_W'(STAGES);
        end
        return DEP_W'(f);
    endfunction

    always_comb begin
        depth_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_i[i] && (clamp_f(REQ_DEPTH[i*DEPTH_W +: DEPTH_W]) > depth_o)) begin
                depth_o = clamp_f(REQ_DEPTH[i*DEPTH_W +: DEPTH_W]);
            end
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: thermometer stall vector from prioritised
// requests, held redirect flush, saturating stall statistics and watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned STAGES     = STALL_BUS_W,
    parameter int unsigned NREQ       = NREQ_DEF,
    parameter int unsigned DEPTH_W    = DEPTH_W_DEF,
    parameter logic [NREQ*DEPTH_W-1:0] REQ_DEPTH = REQ_DEPTH_DEF,
    parameter int unsigned FLUSH_HOLD = 1,
    parameter int unsigned WDOG       = 1024,
    parameter int unsigned CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   stall_req,
    input  logic              excp_valid,
    input  logic [PC_W-1:0]   excp_pc,
    input  logic              dbg_halt,
    input  logic              stat_clr,
    output logic [STAGES-1:0] stall,
    output logic              flush,
    output logic [PC_W-1:0]   new_pc,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic              wdog_err
);

    localparam int unsigned DEP_W = $clog2(STAGES + 1);
    localparam int unsigned RUN_W = $clog2(WDOG + 1);

    flush_state_e      state_q;
    logic [HOLD_W-1:0] hold_q;
    logic [PC_W-1:0]   pc_q;
    redirect_t         redir;

    logic [DEP_W-1:0]  depth;
    logic [STAGES-1:0] therm;
    logic              stall_any;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              wdog_q, wdog_d;

    stall_depth_max #(
        .NREQ      (NREQ),
        .DEPTH_W   (DEPTH_W),
        .STAGES    (STAGES),
        .REQ_DEPTH (REQ_DEPTH),
        .DEP_W     (DEP_W)
    ) u_depth (
        .req_i   (stall_req),
        .depth_o (depth)
    );

    // Flush-hold FSM: a new redirect always reloads the hold and the latched PC
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FL_IDLE;
            hold_q  <= '0;
            pc_q    <= '0;
        end else if (excp_valid) begin
            pc_q    <= excp_pc;
            hold_q  <= HOLD_W'(FLUSH_HOLD - 1);
            state_q <= (FLUSH_HOLD > 1) ? FL_HOLD : FL_IDLE;
        end else if (state_q == FL_HOLD) begin
            hold_q <= hold_q - HOLD_W'(1);
            if (hold_q == HOLD_W'(1)) begin
                state_q <= FL_IDLE;
            end
        end
    end

    always_comb begin
        redir = '0;
        if (excp_valid) begin
            redir = '{flush: 1'b1, pc: excp_pc};
        end else if (state_q == FL_HOLD) begin
            redir = '{flush: 1'b1, pc: pc_q};
        end
        if (!rst) begin
            redir = '0;
        end
    end

    assign flush  = redir.flush;
    assign new_pc = redir.pc;

    // Flush overrides debug halt, which overrides the request-derived depth
    always_comb begin
        therm = '0;
        for (int i = 0; i < STAGES; i++) begin
            therm[i] = (DEP_W'(i) < depth);
        end
        if (!rst || redir.flush) begin
            stall = '0;
        end else if (dbg_halt) begin
            stall = '1;
        end else begin
            stall = therm;
        end
    end

    assign stall_any = |stall;

    always_comb begin
        cnt_d  = cnt_q;
        run_d  = run_q;
        wdog_d = wdog_q;
        if (stat_clr) begin
            cnt_d  = '0;
            run_d  = '0;
            wdog_d = 1'b0;
        end else begin
            if (stall_any && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            // Halted cycles neither extend nor break a stall run
            if (!stall_any) begin
                run_d = '0;
            end else if (!dbg_halt && (run_q != RUN_W'(WDOG))) begin
                run_d = run_q + RUN_W'(1);
            end
            if (run_d == RUN_W'(WDOG)) begin
                wdog_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            run_q  <= '0;
            wdog_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            wdog_q <= wdog_d;
        end
    end

    assign stall_cnt = cnt_q;
    assign wdog_err  = wdog_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed and randomized checks of pipe_ctrl against a cycle-level
// behavioural model of stall depth, flush hold and stall statistics.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int unsigned ST = 6;
    localparam int unsigned NR = 5;
    localparam int unsigned FH = 3;
    localparam int unsigned WD = 8;
    localparam int unsigned CW = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NR-1:0] stall_req = '0;
    logic          excp_valid = 1'b0;
    logic [31:0]   excp_pc = '0;
    logic          dbg_halt = 1'b0;
    logic          stat_clr = 1'b0;
    logic [ST-1:0] stall;
    logic          flush;
    logic [31:0]   new_pc;
    logic [CW-1:0] stall_cnt;
    logic          wdog_err;

    pipe_ctrl #(
        .FLUSH_HOLD (FH),
        .WDOG       (WD),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_req  (stall_req),
        .excp_valid (excp_valid),
        .excp_pc    (excp_pc),
        .dbg_halt   (dbg_halt),
        .stat_clr   (stat_clr),
        .stall      (stall),
        .flush      (flush),
        .new_pc     (new_pc),
        .stall_cnt  (stall_cnt),
        .wdog_err   (wdog_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: remaining extra flush cycles, latched PC, counters
    int            dep [NR];
    int            m_left = 0;
    logic [31:0]   m_pc   = '0;
    int            m_cnt  = 0;
    int            m_run  = 0;
    bit            m_wdog = 1'b0;
    logic [ST-1:0] e_stall;
    logic          e_flush;
    logic [31:0]   e_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_left = 0;
        m_pc   = '0;
        m_cnt  = 0;
        m_run  = 0;
        m_wdog = 1'b0;
    endtask

    task automatic model_comb();
        int d;
        d = 0;
        for (int i = 0; i < NR; i++) begin
            if (stall_req[i] && dep[i] > d) d = dep[i];
        end
        if (d > ST) d = ST;
        e_flush = excp_valid || (m_left > 0);
        e_pc    = excp_valid ? excp_pc : ((m_left > 0) ? m_pc : 32'h0);
        if (e_flush)       e_stall = '0;
        else if (dbg_halt) e_stall = '1;
        else               e_stall = ST'((1 << d) - 1);
    endtask

    // Apply inputs for the current cycle and compare all outputs to the model
    task automatic drive(input logic [NR-1:0] req, input logic ev, input logic [31:0] pc,
                         input logic halt, input logic clr);
        stall_req  = req;
        excp_valid = ev;
        excp_pc    = pc;
        dbg_halt   = halt;
        stat_clr   = clr;
        #1;
        model_comb();
        chk("stall",     32'(stall),     32'(e_stall));
        chk("flush",     32'(flush),     32'(e_flush));
        chk("new_pc",    new_pc,         e_pc);
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        chk("wdog_err",  32'(wdog_err),  32'(m_wdog));
    endtask

    task automatic tick();
        if (excp_valid) begin
            m_left = FH - 1;
            m_pc   = excp_pc;
        end else if (m_left > 0) begin
            m_left--;
        end
        if (stat_clr) begin
            m_cnt  = 0;
            m_run  = 0;
            m_wdog = 1'b0;
        end else begin
            if (e_stall != '0 && m_cnt < CNT_MAX) m_cnt++;
            if (e_stall == '0)                  m_run = 0;
            else if (!dbg_halt && m_run < WD)   m_run++;
            if (m_run == WD)                    m_wdog = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NR-1:0] r;
        dep[EX]   = 4;
        dep[BRU]  = 3;
        dep[CP0]  = 3;
        dep[LOAD] = 2;
        dep[FIFO] = 1;

        // Outputs held at zero in reset regardless of inputs
        stall_req  = '1;
        excp_valid = 1'b1;
        excp_pc    = 32'h1234_5678;
        dbg_halt   = 1'b1;
        #2;
        chk("rst_stall",  32'(stall),     32'h0);
        chk("rst_flush",  32'(flush),     32'h0);
        chk("rst_new_pc", new_pc,         32'h0);
        chk("rst_cnt",    32'(stall_cnt), 32'h0);
        chk("rst_wdog",   32'(wdog_err),  32'h0);
        stall_req  = '0;
        excp_valid = 1'b0;
        excp_pc    = '0;
        dbg_halt   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive('0, 1'b0, '0, 1'b0, 1'b0);
        tick();

        // ex+bru -> depth 4, counter steps by one
        drive(5'b00011, 1'b0, '0, 1'b0, 1'b0);
        chk("exbru_stall", 32'(stall), 32'(6'b001111));
        chk("exbru_cnt0",  32'(stall_cnt), 32'd0);
        tick();
        drive('0, 1'b0, '0, 1'b0, 1'b0);
        chk("exbru_cnt1", 32'(stall_cnt), 32'd1);

        // fifo only -> depth 1, then debug halt freezes all stages
        drive(5'b10000, 1'b0, '0, 1'b0, 1'b0);
        chk("fifo_stall", 32'(stall), 32'(6'b000001));
        drive(5'b10000, 1'b0, '0, 1'b1, 1'b0);
        chk("halt_stall", 32'(stall), 32'(6'b111111));
        tick();
        drive('0, 1'b0, '0, 1'b0, 1'b0);
        tick();

        // Single redirect held for three cycles with stall forced low
        drive('0, 1'b1, 32'hBFC0_0380, 1'b0, 1'b0);
        chk("fl0_flush", 32'(flush), 32'd1);
        chk("fl0_pc",    new_pc,     32'hBFC0_0380);
        tick();
        for (int k = 1; k < 3; k++) begin
            drive('1, 1'b0, '0, 1'b1, 1'b0);
            chk("flh_flush", 32'(flush), 32'd1);
            chk("flh_pc",    new_pc,     32'hBFC0_0380);
            chk("flh_stall", 32'(stall), 32'd0);
            tick();
        end
        drive('0, 1'b0, '0, 1'b0, 1'b0);
        chk("fl_end", 32'(flush), 32'd0);
        tick();

        // Second redirect during hold cycle 2 restarts the hold
        drive('0, 1'b1, 32'hBFC0_0380, 1'b0, 1'b0);
        tick();
        drive('0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        drive('0, 1'b1, 32'h8000_0180, 1'b0, 1'b0);
        chk("re_pc", new_pc, 32'h8000_0180);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive('0, 1'b0, '0, 1'b0, 1'b0);
            chk("re_flush", 32'(flush), 32'd1);
            chk("re_hold_pc", new_pc, 32'h8000_0180);
            tick();
        end
        drive('0, 1'b0, '0, 1'b0, 1'b0);
        chk("re_end", 32'(flush), 32'd0);
        tick();

        // Watchdog after 8 consecutive stalled cycles, sticky until clear
        drive('0, 1'b0, '0, 1'b0, 1'b1);
        tick();
        for (int k = 0; k < 8; k++) begin
            drive(5'b00001, 1'b0, '0, 1'b0, 1'b0);
            tick();
        end
        drive('0, 1'b0, '0, 1'b0, 1'b0);
        chk("wd_set", 32'(wdog_err), 32'd1);
        tick();
        drive('0, 1'b0, '0, 1'b0, 1'b0);
        chk("wd_sticky", 32'(wdog_err), 32'd1);
        drive('0, 1'b0, '0, 1'b0, 1'b1);
        tick();
        drive('0, 1'b0, '0, 1'b0, 1'b0);
        chk("wd_clr",  32'(wdog_err),  32'd0);
        chk("cnt_clr", 32'(stall_cnt), 32'd0);
        tick();

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            r = NR'($urandom);
            if ($urandom_range(0, 3) == 0) r = '0;
            drive(r, ($urandom_range(0, 7) == 0), $urandom,
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 47) == 0));
            tick();
        end

        // Reset dropped mid-hold aborts the flush
        drive(5'b00001, 1'b0, '0, 1'b0, 1'b0);
        tick();
        drive('0, 1'b1, 32'hBFC0_0380, 1'b0, 1'b0);
        tick();
        drive('1, 1'b0, '0, 1'b0, 1'b0);
        chk("mid_hold", 32'(flush), 32'd1);
        rst = 1'b0;
        #1;
        model_reset();
        chk("rsth_flush", 32'(flush),     32'd0);
        chk("rsth_pc",    new_pc,         32'd0);
        chk("rsth_cnt",   32'(stall_cnt), 32'd0);
        chk("rsth_stall", 32'(stall),     32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive('0, 1'b0, '0, 1'b0, 1'b0);
            chk("post_rst_flush", 32'(flush), 32'd0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
